// File: rtl/ophd_exception_sequencer.sv
// ophd_exception_sequencer
// Runs the exception work that the opcode-head decoder only flags.
// At each opcode-head boundary it arbitrates in the order BUSRQ, then NMI, then INT.
// It owns IFF1/IFF2 and the one-instruction EI delay.
// It runs the bus-release, NMI and INT (IM0/1/2) acknowledge sequences through
// handshakes with the bus unit and the datapath.
// It hands back either a restart vector or an IM0 opcode.
module ophd_exception_sequencer #(
    parameter logic [15:0] NMI_VEC = 16'h0066,
    parameter logic [15:0] IM1_VEC = 16'h0038
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ophd,
    input  logic        BUSRQ,
    input  logic        TNMI,
    input  logic        TINT,
    input  logic [1:0]  IM,
    input  logic [7:0]  Ireg,
    input  logic        ei,
    input  logic        di,
    input  logic        retn,
    output logic        BUSAK,
    output logic        Reset_TNMI,
    output logic        IFF1,
    output logic        IFF2,
    output logic        iack_req,
    input  logic        iack_done,
    input  logic [7:0]  iack_data,
    output logic        push_req,
    input  logic        push_done,
    output logic        rd_req,
    output logic [15:0] rd_addr,
    input  logic        rd_done,
    input  logic [7:0]  rd_data,
    output logic        vec_valid,
    output logic [15:0] vec,
    output logic        op_valid,
    output logic [7:0]  op,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE,
        BUSREL,
        NMI_PUSH,
        INT_ACK,
        OP_OUT,
        INT_PUSH,
        RD_LO,
        RD_HI,
        VECTOR
    } state_t;

    state_t      state_q, state_d;
    logic        iff1_q, iff1_d;
    logic        iff2_q, iff2_d;
    logic        ei_pend_q, ei_pend_d;
    logic        rst_tnmi_q, rst_tnmi_d;
    logic        im2_q, im2_d;
    logic [15:0] vec_q, vec_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  data_q, data_d;

    // State register and the datapath registers that travel with it.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            iff1_q     <= 1'b0;
            iff2_q     <= 1'b0;
            ei_pend_q  <= 1'b0;
            rst_tnmi_q <= 1'b0;
            im2_q      <= 1'b0;
            vec_q      <= 16'h0000;
            addr_q     <= 16'h0000;
            data_q     <= 8'h00;
        end else begin
            // NOTE: non-blocking here so every register samples the pre-edge value of the others.
            state_q    <= state_d;
            iff1_q     <= iff1_d;
            iff2_q     <= iff2_d;
            ei_pend_q  <= ei_pend_d;
            rst_tnmi_q <= rst_tnmi_d;
            im2_q      <= im2_d;
            vec_q      <= vec_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    // Next-state, IFF bookkeeping and sequence datapath.
    // Later assignments override earlier ones, so the code is written lowest priority first.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        iff1_d     = iff1_q;
        iff2_d     = iff2_q;
        ei_pend_d  = ei_pend_q;
        rst_tnmi_d = 1'b0;
        im2_d      = im2_q;
        vec_d      = vec_q;
        addr_d     = addr_q;
        data_d     = data_q;

        // A pending EI takes effect at the next boundary that is not handed to the bus.
        if (state_q == IDLE && ophd && !BUSRQ && ei_pend_q) begin
            iff1_d    = 1'b1;
            iff2_d    = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (ei) begin
            ei_pend_d = 1'b1;
        end
        if (retn) begin
            iff1_d = iff2_q;
        end
        // DI also cancels a pending EI, so the enable never lands after the disable.
        if (di) begin
            iff1_d    = 1'b0;
            iff2_d    = 1'b0;
            ei_pend_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (ophd) begin
                    if (BUSRQ) begin
                        state_d = BUSREL;
                    end else if (TNMI) begin
                        state_d    = NMI_PUSH;
                        rst_tnmi_d = 1'b1;
                        iff2_d     = iff1_q;
                        iff1_d     = 1'b0;
                        vec_d      = NMI_VEC;
                    end else if (TINT && iff1_q && !ei_pend_q) begin
                        state_d = INT_ACK;
                        iff1_d  = 1'b0;
                        iff2_d  = 1'b0;
                    end
                end
            end
            BUSREL: begin
                if (!BUSRQ) begin
                    state_d = IDLE;
                end
            end
            NMI_PUSH: begin
                if (push_done) begin
                    state_d = VECTOR;
                end
            end
            INT_ACK: begin
                if (iack_done) begin
                    data_d = iack_data;
                    case (IM)
                        2'd0: state_d = OP_OUT;
                        2'd1: begin
                            state_d = INT_PUSH;
                            im2_d   = 1'b0;
                            vec_d   = IM1_VEC;
                        end
                        default: begin
                            state_d = INT_PUSH;
                            im2_d   = 1'b1;
                            addr_d  = {Ireg, iack_data & 8'hFE};
                        end
                    endcase
                end
            end
            OP_OUT: state_d = IDLE;
            INT_PUSH: begin
                if (push_done) begin
                    state_d = im2_q ? RD_LO : VECTOR;
                end
            end
            RD_LO: begin
                if (rd_done) begin
                    vec_d[7:0] = rd_data;
                    addr_d     = addr_q + 16'd1;
                    state_d    = RD_HI;
                end
            end
            RD_HI: begin
                if (rd_done) begin
                    vec_d[15:8] = rd_data;
                    state_d     = VECTOR;
                end
            end
            VECTOR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs are decoded straight from the state, so each request drops on the edge that ends its state.
    assign BUSAK      = (state_q == BUSREL);
    assign Reset_TNMI = rst_tnmi_q;
    assign IFF1       = iff1_q;
    assign IFF2       = iff2_q;
    assign iack_req   = (state_q == INT_ACK);
    assign push_req   = (state_q == NMI_PUSH) || (state_q == INT_PUSH);
    assign rd_req     = (state_q == RD_LO) || (state_q == RD_HI);
    assign rd_addr    = addr_q;
    assign vec_valid  = (state_q == VECTOR);
    assign vec        = vec_q;
    assign op_valid   = (state_q == OP_OUT);
    assign op         = data_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ophd_exception_sequencer.sv
// Directed bench for ophd_exception_sequencer.
// Inputs change 1 time unit after the rising edge, and outputs are compared there as well.
module tb_ophd_exception_sequencer;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ophd = 1'b0, BUSRQ = 1'b0, TNMI = 1'b0, TINT = 1'b0;
    logic [1:0]  IM = 2'd0;
    logic [7:0]  Ireg = 8'h00;
    logic        ei = 1'b0, di = 1'b0, retn = 1'b0;
    logic        BUSAK, Reset_TNMI, IFF1, IFF2, iack_req, push_req, rd_req;
    logic        vec_valid, op_valid, busy;
    logic        iack_done = 1'b0, push_done = 1'b0, rd_done = 1'b0;
    logic [7:0]  iack_data = 8'h00, rd_data = 8'h00, op;
    logic [15:0] rd_addr, vec;

    int vectors = 0;
    int miscompares = 0;

    // Order: busy BUSAK Reset_TNMI IFF1 IFF2 iack_req push_req rd_req vec_valid op_valid
    logic [9:0] flags;
    assign flags = {busy, BUSAK, Reset_TNMI, IFF1, IFF2, iack_req, push_req, rd_req, vec_valid, op_valid};

    ophd_exception_sequencer dut (
        .Clk(Clk), .Reset(Reset), .ophd(ophd), .BUSRQ(BUSRQ), .TNMI(TNMI), .TINT(TINT),
        .IM(IM), .Ireg(Ireg), .ei(ei), .di(di), .retn(retn),
        .BUSAK(BUSAK), .Reset_TNMI(Reset_TNMI), .IFF1(IFF1), .IFF2(IFF2),
        .iack_req(iack_req), .iack_done(iack_done), .iack_data(iack_data),
        .push_req(push_req), .push_done(push_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
        .vec_valid(vec_valid), .vec(vec), .op_valid(op_valid), .op(op), .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pulse_ophd();
        ophd = 1'b1; tick(); ophd = 1'b0;
    endtask

    task automatic pulse_ei();
        ei = 1'b1; tick(); ei = 1'b0;
    endtask

    // EI followed by one boundary leaves IFF1=IFF2=1.
    task automatic enable_ints();
        pulse_ei();
        pulse_ophd();
    endtask

    task automatic do_push();
        push_done = 1'b1; tick(); push_done = 1'b0;
    endtask

    task automatic do_iack(input logic [7:0] d);
        iack_data = d; iack_done = 1'b1; tick(); iack_done = 1'b0;
    endtask

    task automatic do_rd(input logic [7:0] d);
        rd_data = d; rd_done = 1'b1; tick(); rd_done = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        check("reset_flags", {6'd0, flags}, 16'h0000);
        check("reset_vec", vec, 16'h0000);
        check("reset_rdaddr", rd_addr, 16'h0000);
        check("reset_op", {8'd0, op}, 16'h0000);
        Reset = 1'b0;
        tick();
        check("idle_after_reset", {6'd0, flags}, {6'd0, 10'b0000000000});

        // An NMI flag without ophd is ignored
        TNMI = 1'b1; tick(); TNMI = 1'b0;
        check("nmi_no_ophd", {6'd0, flags}, {6'd0, 10'b0000000000});

        // EI delay, then IM1 interrupt
        IM = 2'd1;
        pulse_ei();
        TINT = 1'b1;
        pulse_ophd();
        check("ei_first_ophd", {6'd0, flags}, {6'd0, 10'b0001100000});
        pulse_ophd();
        check("int_taken", {6'd0, flags}, {6'd0, 10'b1000010000});
        tick();
        check("iack_hold", {6'd0, flags}, {6'd0, 10'b1000010000});
        do_push();
        check("stray_push_done", {6'd0, flags}, {6'd0, 10'b1000010000});
        do_iack(8'h00);
        TINT = 1'b0;
        check("im1_push", {6'd0, flags}, {6'd0, 10'b1000001000});
        do_push();
        check("im1_vector_flags", {6'd0, flags}, {6'd0, 10'b1000000010});
        check("im1_vec", vec, 16'h0038);
        tick();
        check("im1_done", {6'd0, flags}, {6'd0, 10'b0000000000});

        // NMI with IFF1=1, then RETN, then DI
        enable_ints();
        check("ints_enabled", {6'd0, flags}, {6'd0, 10'b0001100000});
        TNMI = 1'b1;
        pulse_ophd();
        TNMI = 1'b0;
        check("nmi_entry", {6'd0, flags}, {6'd0, 10'b1010101000});
        tick();
        check("nmi_rtnmi_1cyc", {6'd0, flags}, {6'd0, 10'b1000101000});
        do_push();
        check("nmi_vector_flags", {6'd0, flags}, {6'd0, 10'b1000100010});
        check("nmi_vec", vec, 16'h0066);
        tick();
        check("nmi_done", {6'd0, flags}, {6'd0, 10'b0000100000});
        retn = 1'b1; tick(); retn = 1'b0;
        check("retn_restores", {6'd0, flags}, {6'd0, 10'b0001100000});
        di = 1'b1; tick(); di = 1'b0;
        check("di_clears", {6'd0, flags}, {6'd0, 10'b0000000000});

        // BUSRQ beats NMI and INT; the NMI is taken at the next boundary
        enable_ints();
        BUSRQ = 1'b1; TNMI = 1'b1; TINT = 1'b1;
        pulse_ophd();
        check("busrel_entry", {6'd0, flags}, {6'd0, 10'b1101100000});
        tick();
        check("busrel_hold", {6'd0, flags}, {6'd0, 10'b1101100000});
        BUSRQ = 1'b0;
        tick();
        check("busrel_exit", {6'd0, flags}, {6'd0, 10'b0001100000});
        pulse_ophd();
        TNMI = 1'b0; TINT = 1'b0;
        check("nmi_after_bus", {6'd0, flags}, {6'd0, 10'b1010101000});
        do_push();
        check("nmi2_vec", vec, 16'h0066);
        check("nmi2_vector_flags", {6'd0, flags}, {6'd0, 10'b1000100010});
        tick();

        // Done strobes while IDLE are ignored
        rd_done = 1'b1; iack_done = 1'b1; push_done = 1'b1;
        tick();
        rd_done = 1'b0; iack_done = 1'b0; push_done = 1'b0;
        check("idle_stray_dones", {6'd0, flags}, {6'd0, 10'b0000100000});

        // IM2 vector table read
        enable_ints();
        IM = 2'd2; Ireg = 8'h12; TINT = 1'b1;
        pulse_ophd();
        TINT = 1'b0;
        check("im2_iack", {6'd0, flags}, {6'd0, 10'b1000010000});
        do_iack(8'h35);
        check("im2_push", {6'd0, flags}, {6'd0, 10'b1000001000});
        do_push();
        check("im2_rdlo_flags", {6'd0, flags}, {6'd0, 10'b1000000100});
        check("im2_rdlo_addr", rd_addr, 16'h1234);
        tick();
        check("im2_rdlo_hold", rd_addr, 16'h1234);
        do_rd(8'hCD);
        check("im2_rdhi_flags", {6'd0, flags}, {6'd0, 10'b1000000100});
        check("im2_rdhi_addr", rd_addr, 16'h1235);
        do_rd(8'hAB);
        check("im2_vector_flags", {6'd0, flags}, {6'd0, 10'b1000000010});
        check("im2_vec", vec, 16'hABCD);
        tick();
        check("im2_done", {6'd0, flags}, {6'd0, 10'b0000000000});

        // IM=3 behaves as IM2, top-of-table address
        enable_ints();
        IM = 2'd3; Ireg = 8'hFF; TINT = 1'b1;
        pulse_ophd();
        TINT = 1'b0;
        do_iack(8'hFF);
        do_push();
        check("im3_rdlo_addr", rd_addr, 16'hFFFE);
        do_rd(8'h11);
        check("im3_rdhi_addr", rd_addr, 16'hFFFF);
        do_rd(8'h22);
        check("im3_vec", vec, 16'h2211);
        tick();

        // IM0 opcode handoff, then INT with IFF1=0 is not taken
        enable_ints();
        IM = 2'd0; TINT = 1'b1;
        pulse_ophd();
        do_iack(8'hFF);
        check("im0_op_flags", {6'd0, flags}, {6'd0, 10'b1000000001});
        check("im0_op", {8'd0, op}, 16'h00FF);
        tick();
        check("im0_done", {6'd0, flags}, {6'd0, 10'b0000000000});
        pulse_ophd();
        check("int_masked", {6'd0, flags}, {6'd0, 10'b0000000000});
        TINT = 1'b0;

        // Reset in the middle of INT_ACK
        enable_ints();
        IM = 2'd1; TINT = 1'b1;
        pulse_ophd();
        check("pre_reset_iack", {6'd0, flags}, {6'd0, 10'b1000010000});
        Reset = 1'b1;
        #1;
        check("async_reset", {6'd0, flags}, {6'd0, 10'b0000000000});
        tick();
        check("reset_mid_seq", {6'd0, flags}, {6'd0, 10'b0000000000});
        check("reset_mid_vec", vec, 16'h0000);
        TINT = 1'b0;
        Reset = 1'b0;
        tick();
        check("after_reset_idle", {6'd0, flags}, {6'd0, 10'b0000000000});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
